unibus_arb: RTL and testbench

UNIBUS_ARB -- requirements
Module: unibus_arb

---
 rtl/unibus_arb.sv | 169 ++++++++++++++++
 tb/tb_unibus_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/unibus_arb.sv
// UNIBUS bus arbiter: fans the CPU's BG/NPG daisy chain out to per-slot grants and flags slave timeouts.
// Latency: a slot grant is registered, visible one clock after the first cycle the CPU grant line is high.
// Backpressure: none; a grant is held until the slot answers with SACK or the CPU withdraws it.
//
// Ports:
//   clk, reset (async active-low), bus_init (sync clear)
//   dev_br[4*NDEV] / dev_npr / dev_sack : per-slot requests and SACK (slot k BR7..BR4 at bits 4k+3..4k)
//   bus_bg_in[3:0] / bus_npg_in         : CPU grants BG7..BG4 and NPG
//   bus_msyn / bus_ssyn                 : wire-ORed bus handshake
//   bus_br / bus_npr / bus_sack         : combinational OR of slot requests and SACKs
//   dev_bg / dev_npg                    : registered per-slot grants
//   bus_nxm                             : non-existent memory flag (MSYN without SSYN for TIMEOUT clocks)
module unibus_arb #(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_init,
    input  logic [4*NDEV-1:0]   dev_br,
    input  logic [NDEV-1:0]     dev_npr,
    input  logic [NDEV-1:0]     dev_sack,
    input  logic [3:0]          bus_bg_in,
    input  logic                bus_npg_in,
    input  logic                bus_msyn,
    input  logic                bus_ssyn,
    output logic [3:0]          bus_br,
    output logic                bus_npr,
    output logic                bus_sack,
    output logic [4*NDEV-1:0]   dev_bg,
    output logic [NDEV-1:0]     dev_npg,
    output logic                bus_nxm
);

    localparam int          SW  = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT, HELD} state_t;

    state_t              state_q, state_d;
    // Level encoding doubles as the index into {npg, bg[3:0]}: 0..3 = BR4..BR7, 4 = NPG.
    logic [2:0]          lvl_q, lvl_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [4:0]          hist_q, hist_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [4*NDEV-1:0]   dev_bg_q, dev_bg_d;
    logic [NDEV-1:0]     dev_npg_q, dev_npg_d;

    logic [4:0]             cur_grant;
    logic [4:0]             rise;
    logic                   rise_any;
    logic [2:0]             rise_lvl;
    logic [4:0][NDEV-1:0]   lvl_req;
    logic [NDEV-1:0]        req_vec;
    logic [SW-1:0]          pick_slot;
    logic                   sack_sel;
    logic                   line_sel;

    // Request/SACK fan-in to the CPU is purely combinational.
    always_comb begin
        bus_br = '0;
        for (int k = 0; k < NDEV; k++) begin
            bus_br = bus_br | dev_br[4*k +: 4];
        end
    end

    assign bus_npr  = |dev_npr;
    assign bus_sack = |dev_sack;

    assign cur_grant = {bus_npg_in, bus_bg_in};
    // History is updated every clock, so a rise seen while busy is consumed and never replayed.
    assign rise      = cur_grant & ~hist_q;
    assign rise_any  = |rise;

    always_comb begin
        rise_lvl  = 3'd0;
        lvl_req   = '0;
        pick_slot = '0;
        // Ascending scan: the last rising line found is the highest priority (NPG > BR7 > .. > BR4).
        for (int i = 0; i < 5; i++) begin
            if (rise[i]) rise_lvl = 3'(i);
        end
        for (int k = 0; k < NDEV; k++) begin
            for (int l = 0; l < 4; l++) begin
                lvl_req[l][k] = dev_br[4*k + l];
            end
            lvl_req[4][k] = dev_npr[k];
        end
        req_vec = lvl_req[rise_lvl];
        // Descending scan leaves the lowest-index (nearest the CPU) requester.
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (req_vec[k]) pick_slot = SW'(k);
        end
    end

    assign sack_sel = dev_sack[slot_q];
    assign line_sel = cur_grant[lvl_q];

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                // A rise with no requester at that level is left orphaned for the CPU to time out.
                if (rise_any && (|req_vec)) begin
                    state_d = GRANT;
                    lvl_d   = rise_lvl;
                    slot_d  = pick_slot;
                end
            end
            GRANT: begin
                if (sack_sel)       state_d = HELD;
                else if (!line_sel) state_d = IDLE;
            end
            HELD: begin
                if (!sack_sel && !line_sel) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus_init) begin
            state_d = IDLE;
            lvl_d   = 3'd0;
            slot_d  = '0;
        end

        // Grant outputs are a registered decode of the next state.
        dev_bg_d  = '0;
        dev_npg_d = '0;
        for (int k = 0; k < NDEV; k++) begin
            for (int l = 0; l < 4; l++) begin
                dev_bg_d[4*k + l] = (state_d == GRANT) && (slot_d == SW'(k)) && (lvl_d == 3'(l));
            end
            dev_npg_d[k] = (state_d == GRANT) && (slot_d == SW'(k)) && (lvl_d == 3'd4);
        end

        hist_d = bus_init ? 5'd0 : cur_grant;

        // SSYN clears the counter on the same edge it would have saturated, so SSYN wins.
        if (bus_init || !bus_msyn || bus_ssyn) cnt_d = 16'd0;
        else if (cnt_q == TMO)                 cnt_d = cnt_q;
        else                                   cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lvl_q     <= 3'd0;
            slot_q    <= '0;
            hist_q    <= 5'd0;
            cnt_q     <= 16'd0;
            dev_bg_q  <= '0;
            dev_npg_q <= '0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            slot_q    <= slot_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            dev_bg_q  <= dev_bg_d;
            dev_npg_q <= dev_npg_d;
        end
    end

    assign dev_bg  = dev_bg_q;
    assign dev_npg = dev_npg_q;
    assign bus_nxm = (cnt_q == TMO);

endmodule

// File: tb/tb_unibus_arb.sv
module tb_unibus_arb;

    localparam int NDEV    = 4;
    localparam int TIMEOUT = 10;

    logic                clk;
    logic                reset;
    logic                bus_init;
    logic [4*NDEV-1:0]   dev_br;
    logic [NDEV-1:0]     dev_npr;
    logic [NDEV-1:0]     dev_sack;
    logic [3:0]          bus_bg_in;
    logic                bus_npg_in;
    logic                bus_msyn;
    logic                bus_ssyn;
    logic [3:0]          bus_br;
    logic                bus_npr;
    logic                bus_sack;
    logic [4*NDEV-1:0]   dev_bg;
    logic [NDEV-1:0]     dev_npg;
    logic                bus_nxm;

    int vecs = 0;
    int errs = 0;

    unibus_arb #(.NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_init   (bus_init),
        .dev_br     (dev_br),
        .dev_npr    (dev_npr),
        .dev_sack   (dev_sack),
        .bus_bg_in  (bus_bg_in),
        .bus_npg_in (bus_npg_in),
        .bus_msyn   (bus_msyn),
        .bus_ssyn   (bus_ssyn),
        .bus_br     (bus_br),
        .bus_npr    (bus_npr),
        .bus_sack   (bus_sack),
        .dev_bg     (dev_bg),
        .dev_npg    (dev_npg),
        .bus_nxm    (bus_nxm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus_init   = 1'b0;
        dev_br     = '0;
        dev_npr    = '0;
        dev_sack   = '0;
        bus_bg_in  = 4'b0000;
        bus_npg_in = 1'b0;
        bus_msyn   = 1'b0;
        bus_ssyn   = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_dev_bg",  dev_bg,  32'h0);
        chk("rst_dev_npg", dev_npg, 32'h0);
        chk("rst_nxm",     bus_nxm, 32'h0);

        // Combinational fan-in works regardless of reset.
        dev_br  = 16'h2020;   // slots 1 and 3 BR5
        dev_npr = 4'b0100;
        dev_sack = 4'b1000;
        #1;
        chk("or_bus_br",   bus_br,   32'h2);
        chk("or_bus_npr",  bus_npr,  32'h1);
        chk("or_bus_sack", bus_sack, 32'h1);
        dev_npr  = '0;
        dev_sack = '0;
        #1;
        chk("or_bus_npr0", bus_npr, 32'h0);
        tick(2);
        reset = 1'b1;
        tick(1);

        // Slots 1 and 3 request BR5; slot 1 is nearer and wins.
        bus_bg_in = 4'b0010;
        #1;
        chk("br5_pre_edge", dev_bg, 32'h0);
        tick(1);
        chk("br5_grant", dev_bg, 32'h0020);
        dev_br = 16'h2022;    // slot 0 joins late: must not steal the grant
        tick(1);
        chk("br5_late_req", dev_bg, 32'h0020);
        dev_br = 16'h2002;    // slot 1 drops its request: grant stays
        tick(1);
        chk("br5_req_drop", dev_bg, 32'h0020);
        dev_sack = 4'b0010;
        tick(1);
        chk("br5_sack_clr", dev_bg, 32'h0);
        tick(1);
        chk("br5_held", dev_bg, 32'h0);
        dev_sack  = '0;
        bus_bg_in = 4'b0000;
        dev_br    = '0;
        tick(2);

        // NPG and BG7 rise together: NPG has priority.
        dev_npr    = 4'b0100;
        dev_br     = 16'h0008; // slot 0 BR7
        bus_npg_in = 1'b1;
        bus_bg_in  = 4'b1000;
        tick(1);
        chk("npg_grant", dev_npg, 32'h4);
        chk("npg_no_bg", dev_bg,  32'h0);
        bus_npg_in = 1'b0;     // CPU withdraws before SACK
        tick(1);
        chk("npg_withdrawn", dev_npg, 32'h0);
        tick(1);
        chk("bg7_no_replay", dev_bg, 32'h0);
        bus_bg_in = 4'b0000;
        tick(1);
        bus_bg_in = 4'b1000;
        tick(1);
        chk("bg7_fresh_rise", dev_bg, 32'h0008);
        dev_sack = 4'b0001;
        tick(1);
        chk("bg7_sack", dev_bg, 32'h0);
        dev_sack  = '0;
        bus_bg_in = 4'b0000;
        dev_br    = '0;
        dev_npr   = '0;
        tick(2);

        // Orphan BG4, then a real request with a fresh rise.
        bus_bg_in = 4'b0001;
        tick(1);
        chk("orphan_bg4", dev_bg, 32'h0);
        dev_br = 16'h0001;
        tick(1);
        chk("orphan_no_redetect", dev_bg, 32'h0);
        bus_bg_in = 4'b0000;
        tick(1);
        bus_bg_in = 4'b0001;
        tick(1);
        chk("bg4_slot0", dev_bg, 32'h0001);
        bus_bg_in = 4'b0000;
        tick(1);
        chk("bg4_withdraw", dev_bg, 32'h0);
        dev_br = '0;
        tick(1);

        // Slave timeout.
        bus_msyn = 1'b1;
        tick(9);
        chk("nxm_at9", bus_nxm, 32'h0);
        tick(1);
        chk("nxm_at10", bus_nxm, 32'h1);
        tick(3);
        chk("nxm_saturated", bus_nxm, 32'h1);
        bus_msyn = 1'b0;
        tick(1);
        chk("nxm_clear", bus_nxm, 32'h0);
        bus_msyn = 1'b1;
        tick(9);
        bus_ssyn = 1'b1;       // SSYN on the edge the counter would hit TIMEOUT
        tick(1);
        chk("ssyn_wins", bus_nxm, 32'h0);
        tick(3);
        chk("ssyn_hold", bus_nxm, 32'h0);
        bus_msyn = 1'b0;
        bus_ssyn = 1'b0;
        tick(1);

        // bus_init drops a grant; async reset zeros outputs mid-cycle.
        dev_br    = 16'h4000;  // slot 3 BR6
        bus_bg_in = 4'b0100;
        tick(1);
        chk("br6_grant", dev_bg, 32'h4000);
        bus_init = 1'b1;
        tick(1);
        chk("init_clear", dev_bg, 32'h0);
        bus_init = 1'b0;
        tick(1);
        chk("init_rerise", dev_bg, 32'h4000);
        bus_msyn = 1'b1;
        tick(TIMEOUT);
        chk("nxm_before_rst", bus_nxm, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_dev_bg", dev_bg,  32'h0);
        chk("arst_nxm",    bus_nxm, 32'h0);
        bus_msyn = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("post_rst_rise", dev_bg, 32'h4000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
